// File: rtl/result_tx_packer_if.sv
// Result-to-UART handshake bundle.
// The master side issues results and observes the byte stream.
// The slave side is the packer itself.
interface result_tx_packer_if;
    logic        res_valid;
    logic [23:0] res_data;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        busy;
    logic        res_drop;

    modport master (
        output res_valid,
        output res_data,
        input  tx_ready,
        input  tx_data,
        input  busy,
        input  res_drop
    );

    modport slave (
        input  res_valid,
        input  res_data,
        output tx_ready,
        output tx_data,
        output busy,
        output res_drop
    );
endinterface

// File: rtl/result_tx_packer.sv
// result_tx_packer: turns one 24-bit result into a 5-byte frame for tx_uart.
// The frame is HDR, res[23:16], res[15:8], res[7:0], CHK, where CHK is the
// XOR of the first four bytes. Each byte is announced by a one-cycle tx_ready
// pulse. Consecutive pulses are GAP_CLKS cycles apart, which leaves room for
// one UART character plus guard.
module result_tx_packer #(
    parameter int         GAP_CLKS = 57288,
    parameter logic [7:0] HDR      = 8'h52
) (
    input  logic                clk,
    input  logic                rst,
    result_tx_packer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    // The GAP state spans GAP_CLKS-1 cycles. The counter therefore ends at GAP_CLKS-2.
    localparam logic [16:0] GAP_LAST = 17'(GAP_CLKS - 2);
    localparam logic [2:0]  LAST_IDX = 3'd4;

    state_t      state_r;
    logic [23:0] res_r;
    logic [2:0]  byte_idx_r;
    logic [16:0] gap_cnt_r;
    logic        tx_ready_r;
    logic [7:0]  tx_data_r;
    logic        busy_r;
    logic        res_drop_r;
    // This flag is cleared by reset and set on the first clock edge after release.
    // While it is clear, a res_valid that coincides with the release edge is ignored.
    logic        armed_r;

    // XOR checksum over header and the three result bytes.
    function automatic logic [7:0] frame_chk(input logic [23:0] res);
        frame_chk = HDR ^ res[23:16] ^ res[15:8] ^ res[7:0];
    endfunction

    // Selects the frame byte at position idx.
    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [23:0] res);
        case (idx)
            3'd0:    frame_byte = HDR;
            3'd1:    frame_byte = res[23:16];
            3'd2:    frame_byte = res[15:8];
            3'd3:    frame_byte = res[7:0];
            3'd4:    frame_byte = frame_chk(res);
            default: frame_byte = 8'h00;
        endcase
    endfunction

    // Frame sequencer. The outputs are registered, so each tx_ready pulse and
    // its byte are loaded on the edge that enters SEND.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            res_r      <= 24'h000000;
            byte_idx_r <= 3'd0;
            gap_cnt_r  <= 17'd0;
            tx_ready_r <= 1'b0;
            tx_data_r  <= 8'h00;
            busy_r     <= 1'b0;
            res_drop_r <= 1'b0;
            armed_r    <= 1'b0;
        end else begin
            armed_r    <= 1'b1;
            tx_ready_r <= 1'b0;
            res_drop_r <= bus.res_valid && (state_r != IDLE);
            case (state_r)
                IDLE: begin
                    if (bus.res_valid && armed_r) begin
                        res_r      <= bus.res_data;
                        byte_idx_r <= 3'd0;
                        gap_cnt_r  <= 17'd0;
                        tx_ready_r <= 1'b1;
                        tx_data_r  <= HDR;
                        busy_r     <= 1'b1;
                        state_r    <= SEND;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                SEND: begin
                    gap_cnt_r <= 17'd0;
                    state_r   <= GAP;
                end
                GAP: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        if (byte_idx_r < LAST_IDX) begin
                            byte_idx_r <= byte_idx_r + 3'd1;
                            tx_data_r  <= frame_byte(byte_idx_r + 3'd1, res_r);
                            tx_ready_r <= 1'b1;
                            state_r    <= SEND;
                        end else begin
                            busy_r     <= 1'b0;
                            state_r    <= IDLE;
                        end
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 17'd1;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_ready = tx_ready_r;
    assign bus.tx_data  = tx_data_r;
    assign bus.busy     = busy_r;
    assign bus.res_drop = res_drop_r;

endmodule

// File: doc/result_tx_packer.md
RESULT_TX_PACKER -- requirements
Module: result_tx_packer

Interface
REQ-001 Parameter GAP_CLKS, default 57288, is the clock cycles from one tx_ready start pulse to the next (11 bit periods at 50 MHz / 9600 baud, one bit of guard); legal range 4..2^17-1.
REQ-002 Parameter HDR, default 8'h52, is the frame header byte.
REQ-003 clk  input  1  system clock, rising edge; the single clock domain.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 res_valid  input  1  one-cycle pulse: res_data holds a new 24-bit result.
REQ-006 res_data  input  24  result value, sampled only on an accepted res_valid.
REQ-007 tx_ready  output  1  one-cycle start pulse to tx_uart.
REQ-008 tx_data  output  8  byte for tx_uart, valid with tx_ready and held until the next pulse.
REQ-009 busy  output  1  high while a frame is in progress.
REQ-010 res_drop  output  1  one-cycle pulse: a res_valid was rejected.

Function
REQ-011 Block sits downstream of ctrl_uart and upstream of tx_uart; it converts one 24-bit result into a 5-byte serial frame.
REQ-012 Frame order: HDR, res[23:16], res[15:8], res[7:0], CHK.
REQ-013 CHK = XOR of the four preceding bytes, 8-bit.
REQ-014 FSM states: IDLE, SEND, GAP.
REQ-015 IDLE -> SEND when res_valid=1; res_data is latched into an internal 24-bit register on that edge.
REQ-016 SEND lasts exactly one cycle: tx_ready=1, tx_data=current byte; then -> GAP.
REQ-017 GAP counts GAP_CLKS-1 cycles; at terminal count -> SEND if bytes remain, else -> IDLE.
REQ-018 Latency: res_valid at edge k gives tx_ready=1 with tx_data=HDR in the cycle after edge k.
REQ-019 Pulse spacing between consecutive tx_ready pulses is exactly GAP_CLKS cycles.
REQ-020 Pulse count: exactly 5 tx_ready pulses per accepted result.
REQ-021 busy=1 from the cycle after acceptance until the FSM returns to IDLE.
REQ-022 Busy duration: 5*GAP_CLKS cycles per frame.
REQ-023 Rejection: res_valid while FSM is not IDLE is ignored; res_drop=1 for one cycle on the next edge; the latched result and the frame are unaffected.
REQ-024 Back-to-back: res_valid in the first IDLE cycle after a frame is accepted normally (no dead cycle required beyond IDLE).
REQ-025 Arithmetic: byte index is a 3-bit counter 0..4; it never wraps past 4; the gap counter clears on every SEND.
REQ-026 tx_data holds the last byte sent (CHK) after the frame until the next SEND.

Reset
REQ-027 rst=1 forces IDLE immediately, without waiting for clk.
REQ-028 Reset values: tx_ready=0, tx_data=8'h00, busy=0, res_drop=0, counters=0, latched result=0.
REQ-029 Reset mid-frame abandons the frame; after rst falls, no further tx_ready occurs until a new res_valid.
REQ-030 res_valid coincident with the rst release edge is ignored.

Verification (GAP_CLKS overridden to 16)
REQ-031 res_data=24'h000019 pulsed -> tx_data sequence 52,00,00,19,4B, one tx_ready per byte, 16 cycles apart, first pulse 1 cycle after res_valid.
REQ-032 res_data=24'hABCDEF -> bytes 52,AB,CD,EF,DB; busy high exactly 80 cycles.
REQ-033 res_valid again 10 cycles into a frame -> res_drop pulse 1 cycle later; frame bytes unchanged; no sixth pulse.
REQ-034 rst asserted between bytes 2 and 3 -> all outputs at reset values without a clk edge; no tx_ready for 100 cycles after release.
REQ-035 res_valid on the first IDLE cycle after a frame -> new frame starts next cycle, res_drop stays 0.
REQ-036 Default GAP_CLKS with tx_uart connected, result 24'h000003 -> rx line decodes 52,00,00,03,51 at 9600 baud with no framing error.
